// File: rtl/neuron_mac_preact_pkg.sv
// Shared Q8.8 constants and FSM state encoding for the neuron pre-activation MAC.
package neuron_mac_preact_pkg;

    localparam int Q88_W     = 16;
    localparam int FRAC_BITS = 8;

    localparam logic [Q88_W-1:0] Q88_MAX = 16'h7FFF;
    localparam logic [Q88_W-1:0] Q88_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_mac_preact_if.sv
// Tap-in / result-out bus of the MAC; the DUT uses the slave modport.
interface neuron_mac_preact_if;
    import neuron_mac_preact_pkg::*;

    // Handshakes: a beat moves on a rising edge where valid && ready; the
    // source holds its payload steady while valid && !ready.
    logic        start;
    logic [15:0] bias_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        len_err;
    logic        busy;
    state_t      dbg_state;

    modport slave (
        input  start, bias_in, in_valid, x_in, w_in, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, len_err, busy, dbg_state
    );

    modport master (
        output start, bias_in, in_valid, x_in, w_in, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, len_err, busy, dbg_state
    );

endinterface

// File: rtl/neuron_mac_preact_sat_q88.sv
// Combinational clip of a wide signed accumulator to Q8.8 with a clip flag.
module sat_q88
    import neuron_mac_preact_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [Q88_W-1:0] q_o,
    output logic                    clip_o
);

    localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'($signed(Q88_MAX));
    localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'($signed(Q88_MIN));

    always_comb begin
        q_o    = acc_i[Q88_W-1:0];
        clip_o = 1'b0;
        if (acc_i > MAX_EXT) begin
            q_o    = Q88_MAX;
            clip_o = 1'b1;
        end else if (acc_i < MIN_EXT) begin
            q_o    = Q88_MIN;
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_preact.sv
// Q8.8 dot product plus bias, saturated to 16 bits for the sigmoid stage.
module neuron_mac_preact
    import neuron_mac_preact_pkg::*;
#(
    parameter int N_TAPS = 8,
    parameter int ACC_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    neuron_mac_preact_if.slave  bus
);

    localparam logic [7:0] CNT_LAST = 8'(N_TAPS - 1);

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [7:0]               cnt_q;
    logic [Q88_W-1:0]         out_data_q;
    logic                     out_sat_q;
    logic                     len_err_q;

    logic signed [31:0]       prod;
    logic signed [31:0]       prod_sh;
    logic signed [ACC_W-1:0]  bias_ext;
    logic                     final_tap;
    logic [Q88_W-1:0]         sat_q;
    logic                     sat_clip;

    // Q16.16 product floored back to Q.8 before accumulation.
    assign prod      = $signed(bus.x_in) * $signed(bus.w_in);
    assign prod_sh   = prod >>> FRAC_BITS;
    assign acc_d     = acc_q + ACC_W'(prod_sh);
    assign bias_ext  = ACC_W'($signed(bus.bias_in));
    assign final_tap = bus.in_last || (cnt_q == CNT_LAST);

    sat_q88 #(.ACC_W(ACC_W)) u_sat (
        .acc_i  (acc_d),
        .q_o    (sat_q),
        .clip_o (sat_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= ACCUM;
                        acc_q     <= bias_ext;
                        cnt_q     <= '0;
                        out_sat_q <= 1'b0;
                        len_err_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 8'd1;
                        if (final_tap) begin
                            state_q    <= HOLD;
                            out_data_q <= sat_q;
                            out_sat_q  <= sat_clip;
                            len_err_q  <= !bus.in_last;
                        end
                    end
                end
                HOLD: begin
                    // A start coinciding with the result handshake chains the next dot product.
                    if (bus.out_ready) begin
                        if (bus.start) begin
                            state_q   <= ACCUM;
                            acc_q     <= bias_ext;
                            cnt_q     <= '0;
                            out_sat_q <= 1'b0;
                            len_err_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.len_err   = len_err_q;
    assign bus.dbg_state = state_q;

endmodule
